// File: rtl/retire_stage.sv
// ---------------------------------------------------------------------------
// retire_stage
//
// Consumes the reorder buffer's three-wide retire bundle each cycle. Slot 2
// is the oldest and slot 0 the youngest. Committing slots update the
// architectural map, return their previous physical register to the free
// list and are counted. A committing instruction that needs precise-state
// recovery ends the scan and raises a one-cycle recovery pulse with its
// target PC. A committing halt ends the scan and stops the stage for good.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   retire_valid      per-slot retire strobe (bit 2 = oldest)
//   retire_arch_reg   destination architectural register per slot
//   retire_tnew       newly mapped physical register per slot
//   retire_told       previously mapped physical register per slot
//   retire_precise    per-slot precise-state recovery request
//   retire_target_pc  per-slot recovery target PC
//   retire_halt       per-slot halt instruction flag
//   BPRecoverEN       one-cycle recovery pulse to the ROB and front end
//   recover_pc        fetch redirect PC, meaningful while BPRecoverEN
//   arch_map          committed map table (also the recovery map)
//   free_valid        per-slot freed-register strobe to the free list
//   free_preg         freed physical register per slot
//   halted            sticky program-halt flag
//   retired_count     number of committed instructions (wraps at 2^64)
//
// Every output is registered: results appear one cycle after the bundle.
// ---------------------------------------------------------------------------
module retire_stage #(
  parameter int PR_W   = 6,
  parameter int ARCH_N = 32,
  parameter int XLEN   = 32,
  parameter int ARCH_W = $clog2(ARCH_N)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2:0]                   retire_valid,
  input  logic [2:0][ARCH_W-1:0]       retire_arch_reg,
  input  logic [2:0][PR_W-1:0]         retire_tnew,
  input  logic [2:0][PR_W-1:0]         retire_told,
  input  logic [2:0]                   retire_precise,
  input  logic [2:0][XLEN-1:0]         retire_target_pc,
  input  logic [2:0]                   retire_halt,
  output logic                         BPRecoverEN,
  output logic [XLEN-1:0]              recover_pc,
  output logic [ARCH_N-1:0][PR_W-1:0]  arch_map,
  output logic [2:0]                   free_valid,
  output logic [2:0][PR_W-1:0]         free_preg,
  output logic                         halted,
  output logic [63:0]                  retired_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    HALTED  = 2'd2
  } state_e;

  state_e                        state, state_next;
  logic [ARCH_N-1:0][PR_W-1:0]   map_next;
  logic [2:0]                    free_valid_next;
  logic [2:0][PR_W-1:0]          free_preg_next;
  logic [XLEN-1:0]               recover_pc_next;
  logic [1:0]                    commit_cnt;
  logic                          scan_done;

  // Next-state and slot scan. Slots are visited oldest first, so when
  // several committing slots target the same architectural register the
  // youngest one is written last and wins.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // this block leaves a value unassigned, which would infer a latch.
    state_next      = state;
    map_next        = arch_map;
    free_valid_next = '0;
    free_preg_next  = '0;
    recover_pc_next = recover_pc;
    commit_cnt      = '0;
    scan_done       = 1'b0;

    case (state)
      RUN: begin
        for (int s = 2; s >= 0; s--) begin
          if (retire_valid[s] && !scan_done) begin
            commit_cnt = commit_cnt + 2'd1;
            // Register 0 is hardwired: never remapped, nothing to free.
            if (retire_arch_reg[s] != '0) begin
              map_next[retire_arch_reg[s]] = retire_tnew[s];
              free_valid_next[s]           = 1'b1;
              free_preg_next[s]            = retire_told[s];
            end
            // Halt takes priority over a recovery request in the same slot.
            if (retire_halt[s]) begin
              state_next = HALTED;
              scan_done  = 1'b1;
            end else if (retire_precise[s]) begin
              state_next      = RECOVER;
              recover_pc_next = retire_target_pc[s];
              scan_done       = 1'b1;
            end
          end
        end
      end
      // The ROB still shows stale entries during recovery; ignore them.
      RECOVER: state_next = RUN;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      // NOTE: the map is a bank of flops rather than a RAM, so it can and
      // must be reset; the identity mapping is the architectural start state.
      for (int i = 0; i < ARCH_N; i++) begin
        arch_map[i] <= PR_W'(i);
      end
      BPRecoverEN   <= 1'b0;
      recover_pc    <= '0;
      free_valid    <= '0;
      free_preg     <= '0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_next;
      arch_map      <= map_next;
      BPRecoverEN   <= (state_next == RECOVER);
      recover_pc    <= recover_pc_next;
      free_valid    <= free_valid_next;
      free_preg     <= free_preg_next;
      halted        <= (state_next == HALTED);
      retired_count <= retired_count + 64'(commit_cnt);
    end
  end

endmodule

// File: tb/tb_retire_stage.sv
// ---------------------------------------------------------------------------
// tb_retire_stage
//
// Self-checking bench for retire_stage: a table of directed bundles with
// hand-derived expectations, a halt sequence, then randomized traffic. Each
// cycle every output is compared against a reference model that applies the
// retire rules to a list of committing slots.
// ---------------------------------------------------------------------------
module tb_retire_stage;

  localparam int PR_W   = 6;
  localparam int ARCH_N = 32;
  localparam int XLEN   = 32;

  logic                         clock;
  logic                         reset;
  logic [2:0]                   retire_valid;
  logic [2:0][4:0]              retire_arch_reg;
  logic [2:0][PR_W-1:0]         retire_tnew;
  logic [2:0][PR_W-1:0]         retire_told;
  logic [2:0]                   retire_precise;
  logic [2:0][XLEN-1:0]         retire_target_pc;
  logic [2:0]                   retire_halt;
  logic                         BPRecoverEN;
  logic [XLEN-1:0]              recover_pc;
  logic [ARCH_N-1:0][PR_W-1:0]  arch_map;
  logic [2:0]                   free_valid;
  logic [2:0][PR_W-1:0]         free_preg;
  logic                         halted;
  logic [63:0]                  retired_count;

  retire_stage #(.PR_W(PR_W), .ARCH_N(ARCH_N), .XLEN(XLEN)) dut (
    .clock            (clock),
    .reset            (reset),
    .retire_valid     (retire_valid),
    .retire_arch_reg  (retire_arch_reg),
    .retire_tnew      (retire_tnew),
    .retire_told      (retire_told),
    .retire_precise   (retire_precise),
    .retire_target_pc (retire_target_pc),
    .retire_halt      (retire_halt),
    .BPRecoverEN      (BPRecoverEN),
    .recover_pc       (recover_pc),
    .arch_map         (arch_map),
    .free_valid       (free_valid),
    .free_preg        (free_preg),
    .halted           (halted),
    .retired_count    (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = running, 1 = recovering, 2 = halted
  int          m_mode;
  int          m_map [ARCH_N];
  longint      m_count;
  logic        m_bp;
  logic [31:0] m_pc;
  logic [2:0]  m_fv;
  int          m_fp [3];

  task automatic model_step();
    int q[$];
    int last;
    m_fv = '0;
    m_bp = 1'b0;
    for (int s = 0; s < 3; s++) m_fp[s] = 0;
    if (reset) begin
      for (int i = 0; i < ARCH_N; i++) m_map[i] = i;
      m_mode  = 0;
      m_count = 0;
      m_pc    = '0;
      return;
    end
    if (m_mode == 1) begin
      m_mode = 0;
      return;
    end
    if (m_mode == 2) return;
    // Collect the committing slots, oldest first, stopping after a terminator.
    for (int s = 2; s >= 0; s--) begin
      if (retire_valid[s]) begin
        q.push_back(s);
        if (retire_halt[s] || retire_precise[s]) break;
      end
    end
    foreach (q[k]) begin
      m_count++;
      if (retire_arch_reg[q[k]] != 0) begin
        m_map[retire_arch_reg[q[k]]] = int'(retire_tnew[q[k]]);
        m_fv[q[k]] = 1'b1;
        m_fp[q[k]] = int'(retire_told[q[k]]);
      end
    end
    if (q.size() > 0) begin
      last = q[q.size()-1];
      if (retire_halt[last]) m_mode = 2;
      else if (retire_precise[last]) begin
        m_mode = 1;
        m_bp   = 1'b1;
        m_pc   = retire_target_pc[last];
      end
    end
  endtask

  task automatic compare_all();
    check("BPRecoverEN", 64'(BPRecoverEN), 64'(m_bp));
    if (m_bp) check("recover_pc", 64'(recover_pc), 64'(m_pc));
    check("halted", 64'(halted), 64'(m_mode == 2));
    check("retired_count", retired_count, 64'(m_count));
    check("free_valid", 64'(free_valid), 64'(m_fv));
    for (int s = 0; s < 3; s++)
      if (m_fv[s]) check($sformatf("free_preg[%0d]", s), 64'(free_preg[s]), 64'(m_fp[s]));
    for (int i = 0; i < ARCH_N; i++)
      check($sformatf("arch_map[%0d]", i), 64'(arch_map[i]), 64'(m_map[i]));
  endtask

  task automatic do_cycle();
    @(posedge clock);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic drive_idle();
    retire_valid     = '0;
    retire_arch_reg  = '0;
    retire_tnew      = '0;
    retire_told      = '0;
    retire_precise   = '0;
    retire_target_pc = '0;
    retire_halt      = '0;
  endtask

  // Full bundle with precise/halt cleared; used to prove inputs are ignored.
  task automatic drive_noise();
    retire_valid   = 3'b111;
    retire_precise = '0;
    retire_halt    = '0;
    for (int s = 0; s < 3; s++) begin
      retire_arch_reg[s]  = 5'($urandom_range(1, 31));
      retire_tnew[s]      = PR_W'($urandom);
      retire_told[s]      = PR_W'($urandom);
      retire_target_pc[s] = $urandom;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  precise;
    logic [2:0]  halt;
    int          arch [3];
    int          tnew [3];
    int          told [3];
    logic [2:0]  exp_fv;
    int          exp_inc;
    logic        exp_bp;
    logic [31:0] exp_pc;
    logic        exp_halted;
  } vec_t;

  function automatic vec_t mk(logic [2:0] v, logic [2:0] p, logic [2:0] h,
                              int a2, int a1, int a0, int n2, int n1, int n0,
                              int o2, int o1, int o0, logic [2:0] efv, int einc,
                              logic ebp, logic [31:0] epc, logic ehl);
    vec_t r;
    r.valid = v; r.precise = p; r.halt = h;
    r.arch[2] = a2; r.arch[1] = a1; r.arch[0] = a0;
    r.tnew[2] = n2; r.tnew[1] = n1; r.tnew[0] = n0;
    r.told[2] = o2; r.told[1] = o1; r.told[0] = o0;
    r.exp_fv = efv; r.exp_inc = einc; r.exp_bp = ebp; r.exp_pc = epc;
    r.exp_halted = ehl;
    return r;
  endfunction

  // Fixed per-slot target PCs so the selected slot is visible in recover_pc.
  localparam logic [31:0] PC2 = 32'h0000_2000;
  localparam logic [31:0] PC1 = 32'h0000_1040;
  localparam logic [31:0] PC0 = 32'h0000_3000;

  vec_t   vecs [7];
  longint count_before;
  int     halt_cycles;

  initial begin
    // valid   precise  halt    arch(2,1,0)  tnew(2,1,0)  told(2,1,0)  fv     inc bp  pc    halted
    vecs[0] = mk(3'b111, 3'b000, 3'b000, 3, 4, 7,   40, 41, 42, 3, 4, 7,    3'b111, 3, 0, '0,  0);
    vecs[1] = mk(3'b111, 3'b000, 3'b000, 9, 9, 9,   50, 51, 52, 9, 50, 51,  3'b111, 3, 0, '0,  0);
    vecs[2] = mk(3'b111, 3'b010, 3'b000, 10, 11, 12, 20, 21, 22, 1, 2, 3,   3'b110, 2, 1, PC1, 0);
    vecs[3] = mk(3'b001, 3'b000, 3'b000, 0, 0, 0,   30, 31, 33, 5, 6, 34,   3'b000, 1, 0, '0,  0);
    vecs[4] = mk(3'b101, 3'b000, 3'b000, 5, 6, 8,   44, 45, 46, 5, 6, 8,    3'b101, 2, 0, '0,  0);
    vecs[5] = mk(3'b111, 3'b001, 3'b000, 13, 14, 15, 24, 25, 26, 7, 8, 9,   3'b111, 3, 1, PC0, 0);
    vecs[6] = mk(3'b111, 3'b100, 3'b100, 1, 2, 3,   60, 61, 62, 11, 12, 13, 3'b100, 1, 0, '0,  1);

    // ---- reset ----
    drive_idle();
    reset = 1'b1;
    do_cycle();
    do_cycle();
    reset = 1'b0;
    check("reset arch_map[5]", 64'(arch_map[5]), 64'd5);
    check("reset arch_map[31]", 64'(arch_map[31]), 64'd31);
    check("reset recover_pc", 64'(recover_pc), 64'd0);
    check("reset free_preg", 64'(free_preg), 64'd0);

    // ---- directed table; each bundle is followed by a noise cycle ----
    for (int i = 0; i < 7; i++) begin
      retire_valid   = vecs[i].valid;
      retire_precise = vecs[i].precise;
      retire_halt    = vecs[i].halt;
      for (int s = 0; s < 3; s++) begin
        retire_arch_reg[s] = 5'(vecs[i].arch[s]);
        retire_tnew[s]     = PR_W'(vecs[i].tnew[s]);
        retire_told[s]     = PR_W'(vecs[i].told[s]);
      end
      retire_target_pc[2] = PC2;
      retire_target_pc[1] = PC1;
      retire_target_pc[0] = PC0;
      count_before = m_count;
      do_cycle();
      check($sformatf("vec%0d free_valid", i), 64'(free_valid), 64'(vecs[i].exp_fv));
      check($sformatf("vec%0d count", i), retired_count, 64'(count_before + vecs[i].exp_inc));
      check($sformatf("vec%0d BPRecoverEN", i), 64'(BPRecoverEN), 64'(vecs[i].exp_bp));
      check($sformatf("vec%0d halted", i), 64'(halted), 64'(vecs[i].exp_halted));
      if (vecs[i].exp_bp)
        check($sformatf("vec%0d recover_pc", i), 64'(recover_pc), 64'(vecs[i].exp_pc));
      // During recovery or halt the noise must be ignored.
      count_before = m_count;
      drive_noise();
      do_cycle();
      if (vecs[i].exp_bp || vecs[i].exp_halted) begin
        check($sformatf("vec%0d after free_valid", i), 64'(free_valid), 64'd0);
        check($sformatf("vec%0d after count", i), retired_count, 64'(count_before));
        check($sformatf("vec%0d after BPRecoverEN", i), 64'(BPRecoverEN), 64'd0);
      end
    end

    // ---- halted stays halted; reset clears it ----
    for (int k = 0; k < 3; k++) begin
      drive_noise();
      retire_precise = 3'b010;
      do_cycle();
    end
    check("halt sticky", 64'(halted), 64'd1);
    drive_idle();
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    check("halt cleared", 64'(halted), 64'd0);

    // ---- reset in the middle of a recovery ----
    drive_idle();
    retire_valid   = 3'b100;
    retire_precise = 3'b100;
    retire_arch_reg[2] = 5'd6;
    retire_tnew[2]     = 6'd33;
    retire_told[2]     = 6'd6;
    retire_target_pc   = {PC2, PC1, PC0};
    do_cycle();
    check("pre-reset pulse", 64'(BPRecoverEN), 64'd1);
    drive_noise();
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    check("mid-recover reset pulse", 64'(BPRecoverEN), 64'd0);
    check("mid-recover reset map", 64'(arch_map[6]), 64'd6);

    // ---- randomized traffic ----
    halt_cycles = 0;
    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(0, 59) == 0) || (halt_cycles > 4);
      retire_valid   = 3'($urandom);
      retire_precise = '0;
      retire_halt    = '0;
      for (int s = 0; s < 3; s++) begin
        // Narrow register range makes same-register collisions common.
        retire_arch_reg[s]  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
        retire_tnew[s]      = PR_W'($urandom);
        retire_told[s]      = PR_W'($urandom);
        retire_target_pc[s] = $urandom;
        retire_precise[s]   = ($urandom_range(0, 7) == 0);
        retire_halt[s]      = ($urandom_range(0, 79) == 0);
      end
      do_cycle();
      halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
    end
    reset = 1'b0;
    drive_idle();
    do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- Sits directly downstream of the reorder buffer and consumes its three-wide retire bundle each cycle.
- Slot 2 is the oldest, slot 1 the middle and slot 0 the youngest.
- Commits the architectural register mapping, returns freed physical registers to the free list, and raises the branch-recovery pulse (BPRecoverEN plus target PC) when a retiring instruction needs precise-state recovery.
- Tracks program halt and counts retired instructions.

Parameters:
PR_W, 6, physical register index width
ARCH_N, 32, architectural register count (index width 5)
XLEN, 32, PC width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
retire_valid  in  3  per-slot retire strobe from reorder buffer (bit 2 oldest)
retire_arch_reg  in  3x5  destination architectural register per slot
retire_tnew  in  3xPR_W  new physical register per slot
retire_told  in  3xPR_W  previous physical register per slot
retire_precise  in  3  per-slot precise_state_need
retire_target_pc  in  3xXLEN  per-slot recovery target PC
retire_halt  in  3  per-slot halt instruction flag
BPRecoverEN  out  1  one-cycle recovery pulse to the ROB and front end
recover_pc  out  XLEN  fetch redirect PC, valid while BPRecoverEN
arch_map  out  ARCH_N x PR_W  committed map table, used as the recovery map
free_valid  out  3  per-slot freed-register strobe to the free list
free_preg  out  3xPR_W  freed physical register per slot
halted  out  1  sticky program-halt flag
retired_count  out  64  count of committed instructions

Behaviour:
- Reset values:
  - arch_map[i] = i for every i (identity).
  - BPRecoverEN = 0, recover_pc = 0, free_valid = 0, free_preg = 0, halted = 0, retired_count = 0.
  - State = RUN.
- All outputs are registered: one-cycle latency from the retire inputs.
- States and transitions:
  - RUN: the only state that processes inputs.
  - RECOVER: lasts exactly one cycle. BPRecoverEN = 1 throughout. All retire inputs are ignored, because the ROB still presents stale entries during this cycle. Then returns to RUN.
  - HALTED: terminal; only reset leaves it.
- Slot scan in RUN, from slot 2 down to slot 0:
  - A slot commits if its retire_valid = 1 and no older slot in the same cycle has already terminated the scan.
  - The scan terminates at the first committing slot with retire_precise = 1 or retire_halt = 1.
  - That terminating slot itself commits. Younger slots are squashed: no map update, no free, not counted.
  - If any slot terminates on precise, the next state is RECOVER and recover_pc = that slot's retire_target_pc, both registered.
  - If a slot terminates on halt, the next state is HALTED and halted = 1 from the next cycle.
  - If one slot has both precise and halt set, halt wins: no recovery pulse.
- Per committing slot:
  - If arch_reg != 0: arch_map[arch_reg] <= tnew, free_valid[slot] = 1 and free_preg[slot] = told.
  - If arch_reg == 0: no map update and no free. The slot still counts as retired.
- Same arch_reg in several committing slots in one cycle:
  - The youngest committing slot's tnew wins in arch_map.
  - Every slot still frees its own told.
- retired_count increments by the number of committing slots (0..3). It wraps at 2^64 without saturation.
- free_valid pulses for one cycle only. It is 0 in the RECOVER and HALTED states.
- Valid bits may be non-contiguous (e.g. 3'b101); each valid slot is handled independently under the scan rule.
- Reset in any state, including mid-RECOVER, returns to RUN with reset values the next cycle and drops BPRecoverEN.

Test Plan:
- Reset, then inspect → arch_map[5]=5, arch_map[31]=31, halted=0, retired_count=0, BPRecoverEN=0.
- One cycle of valid=3'b111 with arch regs (3,4,7), tnew (40,41,42), told (3,4,7) → next cycle arch_map[3]=40, [4]=41, [7]=42; free_valid=3'b111, free_preg=(3,4,7); retired_count=3.
- valid=3'b111, all slots arch reg 9, tnew (50,51,52), told (9,50,51) → arch_map[9]=52 (slot 0 wins); free_preg=(9,50,51); count +3.
- valid=3'b111, slot 1 precise=1 with target 0x0000_1040 → slots 2 and 1 commit, slot 0 squashed; next cycle BPRecoverEN=1, recover_pc=0x1040, count +2; during that cycle valid=3'b111 inputs are ignored (map unchanged, free_valid=0); BPRecoverEN=0 the cycle after.
- Slot 2 halt=1 with valid=3'b111 → only slot 2 commits, halted=1 next cycle; later retire inputs change nothing; reset clears halted.
- Slot with arch reg 0 → arch_map[0] stays 0, free_valid bit 0, count still +1.
